// File: rtl/x_reg_seq.sv
// Sequencer for one X_REG (DEPTH x DW, single port, registered read): loads a
// vector from an upstream stream and re-streams it downstream on command.
module x_reg_seq #(
  parameter int DW    = 16,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [AW:0]   LEN,
  input  logic          LOAD_START,
  input  logic          STREAM_START,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [DW-1:0] IN_DATA,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [DW-1:0] OUT_DATA,
  output logic          OUT_LAST,
  output logic          BUSY,
  output logic          LOADED,
  output logic          XR_EN,
  output logic          XR_WRITE,
  output logic [AW-1:0] XR_IDX,
  output logic [DW-1:0] XR_DIN,
  input  logic [DW-1:0] XR_DOUT,
  output logic [1:0]    DBG_STATE
);

  // Handshakes: a word moves on any rising edge where VALID && READY are both
  // high; VALID never drops and the payload never changes while READY is low.

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;
  localparam logic [1:0] S_STREAM = 2'd3;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE     = (AW+1)'(1);

  logic [1:0]  state_q, state_d;
  logic [AW:0] len_q, len_d;
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic        out_valid_q, out_valid_d;

  logic [AW:0] len_eff;
  logic [AW:0] last_idx;
  logic [AW:0] rptr_next;
  logic        out_acc;
  logic        last_acc;

  // Zero or oversize lengths fall back to a full-depth vector.
  assign len_eff   = (LEN == '0 || LEN > DEPTH_W) ? DEPTH_W : LEN;
  assign last_idx  = len_q - ONE;
  assign rptr_next = rptr_q + ONE;
  assign out_acc   = out_valid_q && OUT_READY;
  assign last_acc  = out_acc && (rptr_q == last_idx);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (LOAD_START) begin
          state_d = S_LOAD;
          len_d   = len_eff;
          wptr_d  = '0;
        end
      end
      S_LOAD: begin
        if (IN_VALID) begin
          wptr_d = wptr_q + ONE;
          if (wptr_q == last_idx) state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (LOAD_START) begin
          state_d = S_LOAD;
          len_d   = len_eff;
          wptr_d  = '0;
        end else if (STREAM_START) begin
          state_d = S_STREAM;
          rptr_d  = '0;
        end
      end
      S_STREAM: begin
        // The first STREAM cycle only issues the read of index 0.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (last_acc) begin
          out_valid_d = 1'b0;
          state_d     = S_HOLD;
        end else if (out_acc) begin
          rptr_d = rptr_next;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    XR_EN    = 1'b0;
    XR_WRITE = 1'b0;
    XR_IDX   = '0;
    XR_DIN   = '0;
    case (state_q)
      S_LOAD: begin
        XR_EN    = IN_VALID;
        XR_WRITE = IN_VALID;
        XR_IDX   = wptr_q[AW-1:0];
        XR_DIN   = IN_DATA;
      end
      S_STREAM: begin
        // Re-read the presented index on stall so XR_DOUT stays put; no read
        // is issued once the last word is taken.
        XR_EN  = !last_acc;
        XR_IDX = (out_acc && !last_acc) ? rptr_next[AW-1:0] : rptr_q[AW-1:0];
      end
      default: ;
    endcase
  end

  assign IN_READY  = (state_q == S_LOAD);
  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = XR_DOUT;
  assign OUT_LAST  = out_valid_q && (rptr_q == last_idx);
  assign BUSY      = (state_q == S_LOAD) || (state_q == S_STREAM);
  assign LOADED    = (state_q == S_HOLD);
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_x_reg_seq.sv
// Bench for x_reg_seq: behavioural X_REG memory plus a vector-level reference
// model (loaded words, effective length) checked through an expected queue.
module tb_x_reg_seq;

  logic        clk;
  logic        rst;
  logic [5:0]  len;
  logic        load_start;
  logic        stream_start;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;
  logic        loaded;
  logic        xr_en;
  logic        xr_write;
  logic [4:0]  xr_idx;
  logic [15:0] xr_din;
  logic [15:0] xr_dout;
  logic [1:0]  dbg_state;

  x_reg_seq #(.DW(16), .DEPTH(32), .AW(5)) dut (
    .CLK(clk), .RST(rst), .LEN(len), .LOAD_START(load_start),
    .STREAM_START(stream_start), .IN_VALID(in_valid), .IN_READY(in_ready),
    .IN_DATA(in_data), .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .OUT_DATA(out_data), .OUT_LAST(out_last), .BUSY(busy), .LOADED(loaded),
    .XR_EN(xr_en), .XR_WRITE(xr_write), .XR_IDX(xr_idx), .XR_DIN(xr_din),
    .XR_DOUT(xr_dout), .DBG_STATE(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // X_REG: single port, synchronous write, registered read
  logic [15:0] xr_mem [32];
  always @(posedge clk) begin
    if (xr_en) begin
      if (xr_write) xr_mem[xr_idx] <= xr_din;
      else          xr_dout <= xr_mem[xr_idx];
    end
  end

  // Reference model: the resident vector and its effective length
  logic [15:0] ref_vec [32];
  int          ref_len;
  logic [15:0] load_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_len(input int l);
    return (l == 0 || l > 32) ? 32 : l;
  endfunction

  // Driver: load load_q as a vector of length len_in (called at a negedge)
  task automatic load_vector(input int len_in, input bit gaps, input bit poke, input bit both);
    int n, idx, cyc;
    n = eff_len(len_in);
    ref_len = n;
    for (int i = 0; i < n; i++) ref_vec[i] = load_q[i];
    len = 6'(len_in);
    load_start = 1'b1;
    stream_start = both;
    @(negedge clk);
    load_start = 1'b0;
    stream_start = 1'b0;
    chk("load_busy", 32'(busy), 32'd1);
    chk("load_in_ready", 32'(in_ready), 32'd1);
    chk("load_loaded_clr", 32'(loaded), 32'd0);
    chk("load_no_out_valid", 32'(out_valid), 32'd0);
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 400) begin
      in_valid   = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data    = load_q[idx];
      load_start = poke ? ($urandom_range(0, 4) == 0) : 1'b0;
      len        = 6'($urandom_range(1, 63));
      #1;
      if (in_valid) begin
        chk("load_wr_en", 32'(xr_en), 32'd1);
        chk("load_wr_sel", 32'(xr_write), 32'd1);
        chk("load_wr_idx", 32'(xr_idx), 32'(idx));
        chk("load_wr_din", 32'(xr_din), 32'(load_q[idx]));
        idx++;
      end else begin
        chk("load_no_wr", 32'(xr_en), 32'd0);
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    load_start = 1'b0;
    chk("load_words", 32'(idx), 32'(n));
    chk("loaded_set", 32'(loaded), 32'd1);
    chk("load_busy_clr", 32'(busy), 32'd0);
    chk("load_in_ready_clr", 32'(in_ready), 32'd0);
  endtask

  // Driver + scoreboard: stream the resident vector; abort_at >= 0 asserts
  // reset while that index is presented
  task automatic stream_vector(input bit rand_ready, input bit poke, input int abort_at);
    logic [15:0] exp_q [$];
    int n, cyc, p;
    n = ref_len;
    for (int i = 0; i < n; i++) exp_q.push_back(ref_vec[i]);
    stream_start = 1'b1;
    @(negedge clk);
    stream_start = 1'b0;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 400) begin
      out_ready    = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      stream_start = poke ? ($urandom_range(0, 3) == 0) : 1'b0;
      #1;
      p = n - exp_q.size();
      if (cyc == 0) begin
        chk("first_no_valid", 32'(out_valid), 32'd0);
        chk("first_rd_en", 32'(xr_en), 32'd1);
        chk("first_rd_idx", 32'(xr_idx), 32'd0);
        chk("stream_busy", 32'(busy), 32'd1);
      end else begin
        chk("stream_valid", 32'(out_valid), 32'd1);
        if (abort_at == p) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          out_ready = 1'b0;
          stream_start = 1'b0;
          chk("abort_out_valid", 32'(out_valid), 32'd0);
          chk("abort_loaded", 32'(loaded), 32'd0);
          chk("abort_busy", 32'(busy), 32'd0);
          return;
        end
        chk("stream_last", 32'(out_last), 32'(p == n - 1));
        chk("stream_data", 32'(out_data), 32'(exp_q[0]));
        if (out_ready) begin
          void'(exp_q.pop_front());
          if (p == n - 1) begin
            chk("last_no_read", 32'(xr_en), 32'd0);
          end else begin
            chk("next_rd_en", 32'(xr_en), 32'd1);
            chk("next_rd_idx", 32'(xr_idx), 32'(p + 1));
          end
        end else begin
          chk("stall_rd_en", 32'(xr_en), 32'd1);
          chk("stall_rd_sel", 32'(xr_write), 32'd0);
          chk("stall_rd_idx", 32'(xr_idx), 32'(p));
        end
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    stream_start = 1'b0;
    chk("stream_complete", 32'(exp_q.size()), 32'd0);
    if (!rand_ready) chk("stream_throughput", 32'(cyc), 32'(n + 1));
    chk("stream_end_valid", 32'(out_valid), 32'd0);
    chk("hold_loaded", 32'(loaded), 32'd1);
    chk("hold_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    len = '0;
    load_start = 1'b0;
    stream_start = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    ref_len = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_loaded", 32'(loaded), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_xr_en", 32'(xr_en), 32'd0);
    rst = 1'b0;

    // STREAM_START in IDLE does nothing
    stream_start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    stream_start = 1'b0;
    chk("idle_stream_busy", 32'(busy), 32'd0);
    chk("idle_stream_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Full-depth vector 1..32
    load_q.delete();
    for (int i = 0; i < 32; i++) load_q.push_back(16'(i + 1));
    load_vector(32, 1'b0, 1'b0, 1'b0);
    stream_vector(1'b0, 1'b0, -1);

    // Short vector 20..40
    load_q.delete();
    for (int i = 10; i <= 20; i++) load_q.push_back(16'(2 * i));
    load_vector(11, 1'b0, 1'b0, 1'b0);
    stream_vector(1'b0, 1'b0, -1);

    // LEN=0 means full depth; random data, gaps and backpressure
    load_q.delete();
    for (int i = 0; i < 32; i++) load_q.push_back(16'($urandom_range(0, 65535)));
    load_vector(0, 1'b1, 1'b0, 1'b0);
    stream_vector(1'b1, 1'b0, -1);

    // LEN=8 with ignored starts, backpressure and restreams
    load_q.delete();
    for (int i = 0; i < 8; i++) load_q.push_back(16'($urandom_range(0, 65535)));
    load_vector(8, 1'b1, 1'b1, 1'b0);
    stream_vector(1'b1, 1'b1, -1);
    stream_vector(1'b1, 1'b0, -1);
    stream_vector(1'b0, 1'b1, -1);

    // Oversize LEN from HOLD with both starts together: load wins
    load_q.delete();
    for (int i = 0; i < 32; i++) load_q.push_back(16'($urandom_range(0, 65535)));
    load_vector(40, 1'b0, 1'b0, 1'b1);
    stream_vector(1'b0, 1'b0, -1);

    // Reset on the 5th word, then nothing streams until a new load
    stream_vector(1'b0, 1'b0, 4);
    stream_start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    stream_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("post_rst_no_valid", 32'(out_valid), 32'd0);
      chk("post_rst_idle", 32'(busy), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b0;
    load_q.delete();
    for (int i = 0; i < 3; i++) load_q.push_back(16'($urandom_range(0, 65535)));
    load_vector(3, 1'b1, 1'b0, 1'b0);
    stream_vector(1'b1, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/x_reg_seq.md
Name: x_reg_seq

Overview:
- Controller that sequences one X_REG instance: 32 entries x 16 bit, single port, synchronous write and registered read.
- Loads a vector of LEN words from an upstream valid/ready stream into X_REG at indices 0..LEN-1.
- On command, streams the vector back out in index order toward the systolic array feeder, with valid/ready and a LAST marker.
- Owns every X_REG port; X_REG contents persist, so the vector can be re-streamed without reloading.

Parameters:
- DW, 16, data width; matches X_REG DIN/DOUT.
- DEPTH, 32, X_REG entry count.
- AW, 5, index width, log2(DEPTH).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- LEN  in  AW+1  vector length, sampled on an accepted LOAD_START; 0 or any value >DEPTH is treated as DEPTH.
- LOAD_START  in  1  single-cycle pulse that begins a load.
- STREAM_START  in  1  single-cycle pulse that begins streaming the loaded vector.
- IN_VALID / IN_READY  in / out  1 / 1  upstream handshake.
- IN_DATA  in  DW  upstream word.
- OUT_VALID / OUT_READY  out / in  1 / 1  downstream handshake.
- OUT_DATA  out  DW  downstream word; pass-through of XR_DOUT.
- OUT_LAST  out  1  high with the word at index len-1.
- BUSY  out  1  high in LOAD or STREAM.
- LOADED  out  1  a complete vector is resident in X_REG.
- XR_EN, XR_WRITE  out  1, 1  X_REG enable and write select.
- XR_IDX  out  AW  X_REG index.
- XR_DIN  out  DW  X_REG write data.
- XR_DOUT  in  DW  X_REG read data; valid the cycle after a read edge.

Behaviour:
- Reset, synchronous on RST=1 at a clock edge:
  - state=IDLE; len, wptr and rptr=0.
  - OUT_VALID=0, LOADED=0, BUSY=0, IN_READY=0.
  - XR_EN=0. X_REG contents are not cleared.
  - Reset mid-load or mid-stream aborts immediately; a partial vector is never flagged LOADED.
- States: IDLE, LOAD, HOLD, STREAM.
- IDLE:
  - LOAD_START -> LOAD; latch len; wptr=0.
  - STREAM_START is ignored.
- LOAD:
  - IN_READY=1.
  - XR_EN = XR_WRITE = IN_VALID; XR_IDX=wptr; XR_DIN=IN_DATA. These are combinational, so the write commits on the same edge as the handshake.
  - Each handshake increments wptr. The handshake at wptr==len-1 -> HOLD, with LOADED=1 from the next cycle.
  - Starts are ignored.
- HOLD:
  - LOADED=1; XR_EN=0.
  - LOAD_START -> LOAD, with LOADED=0 from the next cycle.
  - STREAM_START -> STREAM; rptr=0.
  - Both starts in the same cycle: LOAD_START wins.
- STREAM:
  - XR_EN=1, XR_WRITE=0.
  - XR_IDX = rptr when the current word is stalled (OUT_VALID && !OUT_READY), otherwise the next index to issue. Re-reading the same index on stall keeps XR_DOUT stable.
  - OUT_VALID is registered: set the cycle after the read of index i is issued.
  - OUT_DATA = XR_DOUT; OUT_LAST = OUT_VALID && (presented index == len-1).
  - Full throughput: one word per cycle while OUT_READY=1.
  - First OUT_VALID appears 1 cycle after the STREAM entry edge (read of index 0 is issued in the first STREAM cycle).
  - Acceptance of the LAST word -> HOLD with OUT_VALID=0 next cycle; no read is issued past len-1.
  - Starts are ignored.
- OUT_DATA, OUT_VALID and OUT_LAST are stable while stalled.
- Index arithmetic never wraps beyond len-1; with len=DEPTH, index 31 is last and there is no access at 0 after it.

Test Plan:
- Load and stream: LEN=32; load IN_DATA=i+1 for i=0..31 with IN_VALID held high; STREAM_START with OUT_READY=1 -> LOADED after 32 handshakes; OUT_DATA=1..32 on 32 consecutive cycles; OUT_LAST only with 32; back to HOLD.
- Short vector and LEN=0: LEN=11 loading 2*i for i=10..20 (values 20..40) -> stream yields exactly 11 words, LAST on 40. LEN=0 -> behaves as 32.
- Backpressure: random OUT_READY and IN_VALID gaps over a LEN=8 stream -> no duplicated, skipped or changed words during stalls; XR_IDX holds during stalls.
- Restream and reload: two STREAM_STARTs after one load -> identical sequences. LOAD_START with STREAM_START in HOLD -> LOAD entered, LOADED drops, no OUT_VALID.
- Reset mid-stream: RST at the 5th word -> OUT_VALID=0 and LOADED=0 next cycle; a STREAM_START then produces nothing until a new load completes.
- Ignored starts: LOAD_START during LOAD and STREAM_START during STREAM -> no effect on wptr/rptr or output sequence.
